// File: rtl/cpld_sync_pkg.sv
// rtl/cpld_sync_pkg.sv - shared constants for flag crossings between the bus-analyzer and UART domains
package cpld_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    localparam int FLAG_MODE_PULSE  = 0;
    localparam int FLAG_MODE_TOGGLE = 1;

    function automatic bit sync_stages_legal(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - N-flop bit synchronizer with asynchronous active-high reset
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Plain flop-to-flop chain; nothing may sit between stages.
    logic [N-1:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {s[N-2:0], d};
        end
    end

    assign q = s[N-1];

endmodule

// File: rtl/cpld_flag_sync.sv
// rtl/cpld_flag_sync.sv - flag synchronizer emitting one registered pulse per detected event
module cpld_flag_sync
    import cpld_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TOGGLE_MODE = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_in,
    output logic             flag_out,
    output logic             flag_level,
    output logic [CNT_W-1:0] event_cnt
);

    generate
        if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
            $fatal(1, "cpld_flag_sync: SYNC_STAGES must be within 2..4");
        end
    endgenerate

    logic sync_q;
    logic hist;
    logic ev;

    sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (flag_in),
        .q   (sync_q)
    );

    // hist resets to 0, so a flag already high at release counts as an event in both modes.
    assign ev = (TOGGLE_MODE == FLAG_MODE_TOGGLE) ? (sync_q ^ hist) : (sync_q & ~hist);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= 1'b0;
            flag_out  <= 1'b0;
            event_cnt <= '0;
        end else begin
            hist     <= sync_q;
            flag_out <= ev;
            if (ev) begin
                event_cnt <= event_cnt + CNT_W'(1);
            end
        end
    end

    assign flag_level = sync_q;

endmodule

// File: tb/tb_cpld_flag_sync.sv
// tb/tb_cpld_flag_sync.sv - randomized and directed checks of cpld_flag_sync against a history-based model
module tb_cpld_flag_sync;

    logic clk = 1'b0;
    logic rst;
    logic flag_in;

    always #5 clk = ~clk;

    logic       fo_p2, fo_t2, fo_w4, fo_p3;
    logic       fl_p2, fl_t2, fl_w4, fl_p3;
    logic [7:0] cnt_p2, cnt_t2, cnt_p3;
    logic [3:0] cnt_w4;

    cpld_flag_sync #(.SYNC_STAGES(2), .TOGGLE_MODE(0), .CNT_W(8)) u_p2 (
        .clk(clk), .rst(rst), .flag_in(flag_in),
        .flag_out(fo_p2), .flag_level(fl_p2), .event_cnt(cnt_p2));
    cpld_flag_sync #(.SYNC_STAGES(2), .TOGGLE_MODE(1), .CNT_W(8)) u_t2 (
        .clk(clk), .rst(rst), .flag_in(flag_in),
        .flag_out(fo_t2), .flag_level(fl_t2), .event_cnt(cnt_t2));
    cpld_flag_sync #(.SYNC_STAGES(2), .TOGGLE_MODE(0), .CNT_W(4)) u_w4 (
        .clk(clk), .rst(rst), .flag_in(flag_in),
        .flag_out(fo_w4), .flag_level(fl_w4), .event_cnt(cnt_w4));
    cpld_flag_sync #(.SYNC_STAGES(3), .TOGGLE_MODE(0), .CNT_W(8)) u_p3 (
        .clk(clk), .rst(rst), .flag_in(flag_in),
        .flag_out(fo_p3), .flag_level(fl_p3), .event_cnt(cnt_p3));

    int  stg  [4] = '{2, 2, 2, 3};
    bit  tog  [4] = '{0, 1, 0, 0};
    int  mask [4] = '{255, 255, 15, 255};

    // Flag values sampled by every clock edge since reset release; element 0 is edge 1.
    bit  hist [$];
    int  exp_cnt [4];
    bit  prev_fo [4];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit fh(input int k);
        if (k < 1 || k > hist.size()) return 1'b0;
        return hist[k-1];
    endfunction

    function automatic int rising_edges();
        int r = 0;
        for (int k = 1; k <= hist.size(); k++) begin
            if (fh(k) && !fh(k-1)) r++;
        end
        return r;
    endfunction

    task automatic check_all(input string tag);
        logic       fo [4];
        logic       fl [4];
        logic [7:0] cn [4];
        int n;
        bit a, b, e;
        fo = '{fo_p2, fo_t2, fo_w4, fo_p3};
        fl = '{fl_p2, fl_t2, fl_w4, fl_p3};
        cn = '{cnt_p2, cnt_t2, {4'h0, cnt_w4}, cnt_p3};
        n = hist.size();
        for (int i = 0; i < 4; i++) begin
            // Pulse after edge n reflects the sample pair taken SYNC_STAGES edges earlier.
            a = fh(n - stg[i]);
            b = fh(n - stg[i] - 1);
            e = tog[i] ? (a ^ b) : (a & ~b);
            if (e) exp_cnt[i]++;
            chk($sformatf("%s fo[%0d]", tag, i), 32'(fo[i]), 32'(e));
            chk($sformatf("%s lvl[%0d]", tag, i), 32'(fl[i]), 32'(fh(n - stg[i] + 1)));
            chk($sformatf("%s cnt[%0d]", tag, i), 32'(cn[i]), 32'(exp_cnt[i] & mask[i]));
            chk($sformatf("%s dbl[%0d]", tag, i), 32'(prev_fo[i] & fo[i]), 32'd0);
            prev_fo[i] = fo[i];
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) hist.push_back(flag_in);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        #1;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            exp_cnt[i] = 0;
            prev_fo[i] = 1'b0;
        end
        check_all("rst");
        for (int c = 0; c < cyc; c++) step("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        flag_in = 1'b0;
        #2;
        do_reset(2);

        // Three-cycle high pulse, two-stage chain.
        for (int c = 0; c < 2; c++) step("s1_idle");
        flag_in = 1'b1;
        step("s1"); step("s1");
        step("s1");
        chk("s1_edge3_high", 32'(fo_p2), 32'd1);
        flag_in = 1'b0;
        step("s1");
        chk("s1_edge4_low", 32'(fo_p2), 32'd0);
        for (int c = 0; c < 4; c++) step("s1");
        chk("s1_cnt", 32'(cnt_p2), 32'd1);

        // Long hold: one pulse, falling edge silent in pulse mode.
        do_reset(1);
        flag_in = 1'b1;
        for (int c = 0; c < 20; c++) step("s2_hi");
        flag_in = 1'b0;
        for (int c = 0; c < 6; c++) step("s2_lo");
        chk("s2_cnt", 32'(cnt_p2), 32'd1);

        // Toggle every two cycles.
        do_reset(1);
        for (int t = 0; t < 10; t++) begin
            flag_in = ~flag_in;
            step("s3"); step("s3");
        end
        for (int c = 0; c < 6; c++) step("s3_tail");
        chk("s3_toggle_cnt", 32'(cnt_t2), 32'd10);

        // 17 events into a 4-bit counter.
        flag_in = 1'b0;
        do_reset(1);
        for (int ev = 0; ev < 17; ev++) begin
            flag_in = 1'b1; step("s4"); step("s4");
            flag_in = 1'b0; step("s4"); step("s4");
        end
        for (int c = 0; c < 6; c++) step("s4_tail");
        chk("s4_wrap_cnt", 32'(cnt_w4), 32'd1);

        // Reset one cycle after the rise, released with flag still high.
        do_reset(1);
        flag_in = 1'b1;
        step("s5_pre"); step("s5_pre");
        do_reset(2);
        for (int c = 0; c < 8; c++) step("s5_post");
        chk("s5_cnt", 32'(cnt_p2), 32'd1);
        chk("s5_cnt3", 32'(cnt_p3), 32'd1);

        // Random levels held 2..6 cycles.
        flag_in = 1'b0;
        do_reset(1);
        for (int c = 0; c < 320; ) begin
            int hold;
            hold = $urandom_range(6, 2);
            flag_in = 1'($urandom_range(1, 0));
            for (int h = 0; h < hold; h++) step("rnd");
            c += hold;
        end
        flag_in = 1'b0;
        for (int c = 0; c < 8; c++) step("rnd_tail");
        chk("rnd_rise_cnt", 32'(cnt_p3), 32'(rising_edges() & 255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
